// File: rtl/timer_peripheral_pkg.sv
// timer_peripheral_pkg: register offsets, TCON bit indices and default window base
package timer_peripheral_pkg;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;
    localparam logic [4:0]  TH_OFF      = 5'h00;
    localparam logic [4:0]  TL_OFF      = 5'h04;
    localparam logic [4:0]  TCON_OFF    = 5'h08;
    localparam logic [4:0]  LED_OFF     = 5'h0C;
    localparam logic [4:0]  SYSTICK_OFF = 5'h10;
    localparam int EN_BIT = 0;
    localparam int IE_BIT = 1;
    localparam int ST_BIT = 2;
endpackage

// File: rtl/timer_peripheral_prescaler.sv
// timer_prescaler: divides clk by PRESCALE, pulsing o_tick on the last count
module timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);
    logic [W-1:0] r_cnt;
    assign o_tick = i_en & ~i_clr & (r_cnt == LAST);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_clr || o_tick)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/timer_peripheral.sv
// timer_peripheral: bus-mapped reload timer with interrupt, LED register and SysTick counter
module timer_peripheral
    import timer_peripheral_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq,
    output logic [7:0]  led,
    output logic [31:0] systick
);
    logic [31:0] r_th, r_tl, r_systick, r_rdata;
    logic [2:0]  r_tcon;
    logic [7:0]  r_led;
    logic        r_irq;
    logic [4:0]  w_off;
    logic        w_wr, w_rd, w_tick, w_tl_wr, w_tcon_wr, w_ovf_set;
    logic [31:0] w_tl_nxt, w_rmux;
    logic [2:0]  w_tcon_nxt;
    logic        w_unused;

    assign hit       = addr[31:5] == BASE_ADDR[31:5];
    assign w_off     = {addr[4:2], 2'b00};
    assign w_unused  = &{1'b0, addr[1:0]};
    assign w_wr      = mem_write & hit;
    assign w_rd      = mem_read & hit;
    assign w_tl_wr   = w_wr & (w_off == TL_OFF);
    assign w_tcon_wr = w_wr & (w_off == TCON_OFF);

    timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .i_en  (r_tcon[EN_BIT]),
        .i_clr (~r_tcon[EN_BIT]),
        .o_tick(w_tick)
    );

    // A TL write on the overflow edge suppresses both the reload and the status flag
    assign w_ovf_set = w_tick & (&r_tl) & r_tcon[IE_BIT] & ~w_tl_wr;
    assign w_tl_nxt  = w_tl_wr ? wdata : w_tick ? ((&r_tl) ? r_th : r_tl + 32'd1) : r_tl;

    always_comb begin
        w_tcon_nxt = w_tcon_wr ? wdata[2:0] : r_tcon;
        w_tcon_nxt[ST_BIT] = w_tcon_nxt[ST_BIT] | w_ovf_set;
    end

    assign w_rmux = (w_off == TH_OFF)      ? r_th :
                    (w_off == TL_OFF)      ? r_tl :
                    (w_off == TCON_OFF)    ? {29'd0, r_tcon} :
                    (w_off == LED_OFF)     ? {24'd0, r_led} :
                    (w_off == SYSTICK_OFF) ? r_systick : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th      <= '0;
            r_tl      <= '0;
            r_tcon    <= '0;
            r_led     <= '0;
            r_systick <= '0;
            r_rdata   <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && w_off == TH_OFF)
                r_th <= wdata;
            if (w_wr && w_off == LED_OFF)
                r_led <= wdata[7:0];
            r_tl      <= w_tl_nxt;
            r_tcon    <= w_tcon_nxt;
            r_systick <= r_systick + 32'd1;
            r_rdata   <= w_rd ? w_rmux : 32'd0;
            r_irq     <= w_tcon_nxt[IE_BIT] & w_tcon_nxt[ST_BIT];
        end
    end

    assign rdata   = r_rdata;
    assign irq     = r_irq;
    assign led     = r_led;
    assign systick = r_systick;
endmodule

// File: tb/tb_timer_peripheral.sv
// tb_timer_peripheral: directed checks of two timer instances (PRESCALE 1 and 4) on a shared bus
module tb_timer_peripheral;
    localparam logic [31:0] BA = 32'h4000_0000;
    localparam logic [31:0] BB = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata_a, rdata_b, systick_a, systick_b;
    logic        hit_a, hit_b, irq_a, irq_b;
    logic [7:0]  led_a, led_b;
    int          n_checks = 0, n_fail = 0, cyc = 0;

    timer_peripheral #(.BASE_ADDR(BA), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata_a), .hit(hit_a), .irq(irq_a),
        .led(led_a), .systick(systick_a));

    timer_peripheral #(.BASE_ADDR(BB), .PRESCALE(4)) dut_b (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata_b), .hit(hit_b), .irq(irq_b),
        .led(led_b), .systick(systick_b));

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset)
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus(1'b1, 1'b0, a, 32'd0);
        check(tag, a[5] ? rdata_b : rdata_a, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #2;
        check("rst_irq", {31'd0, irq_a}, 32'd0);
        check("rst_systick", systick_a, 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus(1'b1, 1'b0, BA + 32'(i * 4), 32'd0);
            check($sformatf("rst_rd_%0d", i), rdata_a, (i == 4) ? 32'(cyc - 1) : 32'd0);
        end
        check("rst_irq2", {31'd0, irq_a}, 32'd0);

        wr(BA + 32'h00, 32'hFFFF_FFFC);
        wr(BA + 32'h04, 32'hFFFF_FFFE);
        wr(BA + 32'h08, 32'd3);
        rd("tl_0", BA + 32'h04, 32'hFFFF_FFFE);
        rd("tl_max", BA + 32'h04, 32'hFFFF_FFFF);
        rd("tl_reload", BA + 32'h04, 32'hFFFF_FFFC);
        check("irq_set", {31'd0, irq_a}, 32'd1);
        rd("tcon_st", BA + 32'h08, 32'd7);
        rd("tl_fe", BA + 32'h04, 32'hFFFF_FFFE);
        rd("tl_max2", BA + 32'h04, 32'hFFFF_FFFF);
        rd("tl_reload2", BA + 32'h04, 32'hFFFF_FFFC);
        wr(BA + 32'h08, 32'd3);
        rd("tcon_ack", BA + 32'h08, 32'd3);
        check("irq_ack", {31'd0, irq_a}, 32'd0);
        wr(BA + 32'h08, 32'd3);
        rd("tcon_ack_ovf", BA + 32'h08, 32'd7);
        check("irq_ack_ovf", {31'd0, irq_a}, 32'd1);

        wr(BA + 32'h08, 32'd0);
        check("irq_off", {31'd0, irq_a}, 32'd0);
        wr(BA + 32'h04, 32'hFFFF_FFFF);
        wr(BA + 32'h08, 32'd3);
        wr(BA + 32'h04, 32'd5);
        rd("tl_wr_tick", BA + 32'h04, 32'd5);
        rd("tcon_wr_tick", BA + 32'h08, 32'd3);
        check("irq_wr_tick", {31'd0, irq_a}, 32'd0);

        wr(BB + 32'h04, 32'd0);
        wr(BB + 32'h08, 32'd1);
        idle(40);
        rd("tl_ps4", BB + 32'h04, 32'd10);
        wr(BB + 32'h08, 32'd0);
        idle(20);
        rd("tl_hold", BB + 32'h04, 32'd10);
        rd("tcon_hold", BB + 32'h08, 32'd0);
        check("irq_b", {31'd0, irq_b}, 32'd0);

        @(negedge clk);
        addr = 32'h5000_0008;
        #1;
        check("hit_miss", {30'd0, hit_a, hit_b}, 32'd0);
        addr = BA + 32'h08;
        #1;
        check("hit_a", {30'd0, hit_a, hit_b}, 32'd2);
        addr = BB + 32'h08;
        #1;
        check("hit_b", {30'd0, hit_a, hit_b}, 32'd1);
        wr(32'h5000_0008, 32'h0000_0000);
        bus(1'b1, 1'b0, 32'h5000_0008, 32'd0);
        check("miss_rd_a", rdata_a, 32'd0);
        check("miss_rd_b", rdata_b, 32'd0);
        rd("miss_tcon_a", BA + 32'h08, 32'd3);
        bus(1'b1, 1'b1, BB + 32'h04, 32'd77);
        check("rw_same_edge", rdata_b, 32'd10);
        rd("rw_after", BB + 32'h04, 32'd77);
        wr(BA + 32'h10, 32'h1234_5678);
        bus(1'b1, 1'b0, BA + 32'h10, 32'd0);
        check("systick_ro", rdata_a, 32'(cyc - 1));
        wr(BA + 32'h14, 32'hFFFF_FFFF);
        rd("resv_rd", BA + 32'h14, 32'd0);

        wr(BA + 32'h0C, 32'h0000_01A5);
        check("led", {24'd0, led_a}, 32'h0000_00A5);
        rd("led_rd", BA + 32'h0C, 32'h0000_00A5);

        wr(BA + 32'h04, 32'hFFFF_FFFF);
        idle(2);
        check("irq_pre_rst", {31'd0, irq_a}, 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_irq", {31'd0, irq_a}, 32'd0);
        check("async_led", {24'd0, led_a}, 32'd0);
        check("async_tl", dut_a.r_tl, 32'd0);
        check("async_tcon", {29'd0, dut_a.r_tcon}, 32'd0);
        check("async_systick", systick_a, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
